// File: rtl/ysyx_22050612_pkg.sv
// Shared definitions for the writeback unit: load size encodings and
// register file geometry.
package ysyx_22050612_pkg;

   // Load access size as carried on the LSU response.
   typedef enum logic [1:0] {
      LS_B = 2'd0,
      LS_H = 2'd1,
      LS_W = 2'd2,
      LS_D = 2'd3
   } ls_size_e;

   // Register file geometry for the default configuration.
   localparam int REG_ADDR_W = 5;
   localparam int NUM_REGS   = 2 ** REG_ADDR_W;

   // Load data path width; extraction works on eight byte lanes.
   localparam int LOAD_W = 64;

endpackage

// File: rtl/ysyx_22050612_load_ext.sv
// Load data extraction: shifts the addressed bytes of a raw aligned
// doubleword down to bit 0, truncates to the access size and extends.
// Bytes beyond the top of the doubleword read as zero before extension.
module ysyx_22050612_load_ext
   import ysyx_22050612_pkg::*;
(
   input  logic [LOAD_W-1:0] data_i,
   input  logic [1:0]        size_i,
   input  logic              unsigned_i,
   input  logic [2:0]        offset_i,
   output logic [LOAD_W-1:0] result_o
);

   logic [LOAD_W-1:0] shifted;
   logic              fill;

   // Logical shift, so missing upper bytes come in as zero.
   assign shifted = data_i >> {offset_i, 3'b000};

   // Truncate to the access size and replicate the fill bit above it.
   always_comb begin
      // NOTE: every output of this block gets a default first, so no path
      // through the case can leave a value unassigned and infer a latch.
      fill     = 1'b0;
      result_o = shifted;
      case (ls_size_e'(size_i))
         LS_B: begin
            fill     = ~unsigned_i & shifted[7];
            result_o = {{56{fill}}, shifted[7:0]};
         end
         LS_H: begin
            fill     = ~unsigned_i & shifted[15];
            result_o = {{48{fill}}, shifted[15:0]};
         end
         LS_W: begin
            fill     = ~unsigned_i & shifted[31];
            result_o = {{32{fill}}, shifted[31:0]};
         end
         LS_D: begin
            // Full width: signedness has no effect.
            result_o = shifted;
         end
         default: begin
            result_o = shifted;
         end
      endcase
   end

endmodule

// File: rtl/ysyx_22050612_wbu.sv
// Writeback unit: arbitrates EXU results and LSU load responses onto the
// register file write port (LSU has fixed priority), extracts load data,
// tracks pending load destinations for the IDU and counts retired results.
module ysyx_22050612_wbu
   import ysyx_22050612_pkg::*;
#(
   parameter int ADDR_WIDTH = REG_ADDR_W,
   parameter int DATA_WIDTH = LOAD_W
) (
   input  logic                       clk,
   input  logic                       rst,
   // EXU result path
   input  logic                       exu_valid,
   output logic                       exu_ready,
   input  logic [ADDR_WIDTH-1:0]      exu_rd,
   input  logic [DATA_WIDTH-1:0]      exu_data,
   // LSU load response path
   input  logic                       lsu_valid,
   output logic                       lsu_ready,
   input  logic [ADDR_WIDTH-1:0]      lsu_rd,
   input  logic [DATA_WIDTH-1:0]      lsu_data,
   input  logic [1:0]                 lsu_size,
   input  logic                       lsu_unsigned,
   input  logic [2:0]                 lsu_offset,
   // Load issue notification from the IDU side
   input  logic                       iss_valid,
   input  logic [ADDR_WIDTH-1:0]      iss_rd,
   output logic [2**ADDR_WIDTH-1:0]   busy,
   // Register file write port
   output logic                       rf_wen,
   output logic [ADDR_WIDTH-1:0]      rf_waddr,
   output logic [DATA_WIDTH-1:0]      rf_wdata,
   output logic [63:0]                retire_cnt
);

   localparam int NREGS = 2 ** ADDR_WIDTH;

   // Handshake and selected result
   logic                  lsu_hs;
   logic                  exu_hs;
   logic                  acc;
   logic [ADDR_WIDTH-1:0] acc_rd;
   logic [DATA_WIDTH-1:0] acc_data;
   logic [DATA_WIDTH-1:0] load_data;

   // Registered write port, source tag, scoreboard and retire counter
   logic                  wen_q,      wen_d;
   logic [ADDR_WIDTH-1:0] waddr_q,    waddr_d;
   logic [DATA_WIDTH-1:0] wdata_q,    wdata_d;
   logic                  from_lsu_q, from_lsu_d;
   logic [NREGS-1:0]      busy_q,     busy_d;
   logic [63:0]           retire_q,   retire_d;

   // LSU responses are always taken outside reset; EXU waits behind them.
   assign lsu_ready = ~rst;
   assign exu_ready = ~lsu_valid;
   assign lsu_hs    = lsu_valid & lsu_ready;
   assign exu_hs    = exu_valid & exu_ready;
   assign acc       = lsu_hs | exu_hs;

   ysyx_22050612_load_ext u_load_ext (
      .data_i     (lsu_data),
      .size_i     (lsu_size),
      .unsigned_i (lsu_unsigned),
      .offset_i   (lsu_offset),
      .result_o   (load_data)
   );

   // Select the accepted result and form the next write-port contents.
   always_comb begin
      acc_rd     = exu_rd;
      acc_data   = exu_data;
      wen_d      = 1'b0;
      waddr_d    = waddr_q;
      wdata_d    = wdata_q;
      from_lsu_d = from_lsu_q;
      if (lsu_hs) begin
         acc_rd   = lsu_rd;
         acc_data = load_data;
      end
      if (acc) begin
         // x0 results still retire but never reach the register file.
         wen_d      = (acc_rd != '0);
         waddr_d    = acc_rd;
         wdata_d    = acc_data;
         from_lsu_d = lsu_hs;
      end
   end

   // Count every accepted result, including those to x0.
   always_comb begin
      retire_d = retire_q + 64'(acc);
   end

   // Scoreboard: clear on the edge the load is written, then apply any new
   // issue so a same-edge set to the same register wins; x0 is never busy.
   always_comb begin
      busy_d = busy_q;
      if (wen_q && from_lsu_q) begin
         busy_d[waddr_q] = 1'b0;
      end
      if (iss_valid && (iss_rd != '0)) begin
         busy_d[iss_rd] = 1'b1;
      end
      busy_d[0] = 1'b0;
   end

   // State registers; reset also drops a write that was accepted but not
   // yet presented.
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      if (rst) begin
         wen_q      <= 1'b0;
         waddr_q    <= '0;
         wdata_q    <= '0;
         from_lsu_q <= 1'b0;
         busy_q     <= '0;
         retire_q   <= '0;
      end else begin
         wen_q      <= wen_d;
         waddr_q    <= waddr_d;
         wdata_q    <= wdata_d;
         from_lsu_q <= from_lsu_d;
         busy_q     <= busy_d;
         retire_q   <= retire_d;
      end
   end

   assign rf_wen     = wen_q;
   assign rf_waddr   = waddr_q;
   assign rf_wdata   = wdata_q;
   assign busy       = busy_q;
   assign retire_cnt = retire_q;

endmodule

// File: tb/tb_ysyx_22050612_wbu.sv
// Directed bench for the writeback unit. Expected register file writes are
// queued when the stimulus is driven and compared when rf_wen appears.
module tb_ysyx_22050612_wbu;

   logic        clk;
   logic        rst;
   logic        exu_valid;
   logic        exu_ready;
   logic [4:0]  exu_rd;
   logic [63:0] exu_data;
   logic        lsu_valid;
   logic        lsu_ready;
   logic [4:0]  lsu_rd;
   logic [63:0] lsu_data;
   logic [1:0]  lsu_size;
   logic        lsu_unsigned;
   logic [2:0]  lsu_offset;
   logic        iss_valid;
   logic [4:0]  iss_rd;
   logic [31:0] busy;
   logic        rf_wen;
   logic [4:0]  rf_waddr;
   logic [63:0] rf_wdata;
   logic [63:0] retire_cnt;

   typedef struct packed {
      logic [4:0]  addr;
      logic [63:0] data;
   } wr_t;

   wr_t         exp_q[$];
   wr_t         mon_e;
   int          checks;
   int          failures;
   logic [63:0] exp_retire;
   logic [4:0]  last_addr;
   logic [63:0] last_data;

   ysyx_22050612_wbu dut (
      .clk          (clk),
      .rst          (rst),
      .exu_valid    (exu_valid),
      .exu_ready    (exu_ready),
      .exu_rd       (exu_rd),
      .exu_data     (exu_data),
      .lsu_valid    (lsu_valid),
      .lsu_ready    (lsu_ready),
      .lsu_rd       (lsu_rd),
      .lsu_data     (lsu_data),
      .lsu_size     (lsu_size),
      .lsu_unsigned (lsu_unsigned),
      .lsu_offset   (lsu_offset),
      .iss_valid    (iss_valid),
      .iss_rd       (iss_rd),
      .busy         (busy),
      .rf_wen       (rf_wen),
      .rf_waddr     (rf_waddr),
      .rf_wdata     (rf_wdata),
      .retire_cnt   (retire_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One clock: through the active edge, back to the falling edge.
   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic expect_write(input logic [4:0] rd, input logic [63:0] d);
      exp_retire++;
      if (rd != 5'd0) begin
         exp_q.push_back('{addr: rd, data: d});
         last_addr = rd;
         last_data = d;
      end
   endtask

   task automatic send_exu(input logic [4:0] rd, input logic [63:0] d);
      exu_valid = 1'b1;
      exu_rd    = rd;
      exu_data  = d;
      expect_write(rd, d);
      tick();
      exu_valid = 1'b0;
   endtask

   task automatic send_lsu(input logic [4:0] rd, input logic [63:0] raw, input logic [1:0] size,
                           input logic uns, input logic [2:0] off, input logic [63:0] exp);
      lsu_valid    = 1'b1;
      lsu_rd       = rd;
      lsu_data     = raw;
      lsu_size     = size;
      lsu_unsigned = uns;
      lsu_offset   = off;
      expect_write(rd, exp);
      tick();
      lsu_valid = 1'b0;
   endtask

   task automatic issue(input logic [4:0] rd);
      iss_valid = 1'b1;
      iss_rd    = rd;
      tick();
      iss_valid = 1'b0;
   endtask

   // Write monitor: every presented write must match the oldest expectation.
   always @(posedge clk) begin
      #2;
      if (rf_wen === 1'b1) begin
         check("wr_expected", 64'(exp_q.size() != 0), 64'd1);
         if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            check("wr_addr", 64'(rf_waddr), 64'(mon_e.addr));
            check("wr_data", rf_wdata, mon_e.data);
         end
      end
   end

   initial begin
      checks       = 0;
      failures     = 0;
      exp_retire   = '0;
      last_addr    = '0;
      last_data    = '0;
      rst          = 1'b1;
      exu_valid    = 1'b0;
      exu_rd       = '0;
      exu_data     = '0;
      lsu_valid    = 1'b0;
      lsu_rd       = '0;
      lsu_data     = '0;
      lsu_size     = 2'd0;
      lsu_unsigned = 1'b0;
      lsu_offset   = 3'd0;
      iss_valid    = 1'b0;
      iss_rd       = '0;

      // Reset state
      tick();
      tick();
      check("rst_wen", 64'(rf_wen), 64'd0);
      check("rst_waddr", 64'(rf_waddr), 64'd0);
      check("rst_wdata", rf_wdata, 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_retire", retire_cnt, 64'd0);
      check("rst_lsu_ready", 64'(lsu_ready), 64'd0);
      rst = 1'b0;
      #1;
      check("lsu_ready_run", 64'(lsu_ready), 64'd1);
      check("exu_ready_idle", 64'(exu_ready), 64'd1);
      tick();

      // Reset asserted in the same cycle as an EXU write to x5: dropped
      exu_valid = 1'b1;
      exu_rd    = 5'd5;
      exu_data  = 64'h1234;
      rst       = 1'b1;
      tick();
      check("rstw_wen", 64'(rf_wen), 64'd0);
      check("rstw_busy", 64'(busy), 64'd0);
      check("rstw_retire", retire_cnt, 64'd0);
      exu_valid = 1'b0;
      rst       = 1'b0;
      tick();
      check("rstw_wen_after", 64'(rf_wen), 64'd0);

      // Simultaneous producers: LSU x4 first, EXU x3 held and taken next
      exu_valid    = 1'b1;
      exu_rd       = 5'd3;
      exu_data     = 64'hAAAA_0000_0000_0003;
      lsu_valid    = 1'b1;
      lsu_rd       = 5'd4;
      lsu_data     = 64'h0123_4567_89AB_CDEF;
      lsu_size     = 2'd3;
      lsu_unsigned = 1'b0;
      lsu_offset   = 3'd0;
      #1;
      check("sim_exu_ready", 64'(exu_ready), 64'd0);
      check("sim_lsu_ready", 64'(lsu_ready), 64'd1);
      expect_write(5'd4, 64'h0123_4567_89AB_CDEF);
      tick();
      check("sim_first_addr", 64'(rf_waddr), 64'd4);
      lsu_valid = 1'b0;
      #1;
      check("sim_exu_ready2", 64'(exu_ready), 64'd1);
      expect_write(5'd3, 64'hAAAA_0000_0000_0003);
      tick();
      exu_valid = 1'b0;
      check("sim_second_wen", 64'(rf_wen), 64'd1);
      check("sim_retire", retire_cnt, 64'd2);

      // Idle cycle: no write, address and data hold
      tick();
      check("idle_wen", 64'(rf_wen), 64'd0);
      check("idle_waddr_hold", 64'(rf_waddr), 64'(last_addr));
      check("idle_wdata_hold", rf_wdata, last_data);

      // Load extraction, back to back
      send_lsu(5'd6, 64'h80FF_0000_0000_0000, 2'd0, 1'b0, 3'd7, 64'hFFFF_FFFF_FFFF_FF80);
      send_lsu(5'd7, 64'h80FF_0000_0000_0000, 2'd0, 1'b1, 3'd7, 64'h0000_0000_0000_0080);
      send_lsu(5'd8, 64'hAB00_0000_0000_0000, 2'd1, 1'b0, 3'd7, 64'h0000_0000_0000_00AB);
      send_lsu(5'd9, 64'h8765_4321_0000_0000, 2'd2, 1'b0, 3'd4, 64'hFFFF_FFFF_8765_4321);
      send_lsu(5'd9, 64'h8765_4321_0000_0000, 2'd2, 1'b1, 3'd4, 64'h0000_0000_8765_4321);
      send_lsu(5'd11, 64'h0000_0000_7FFF_0000, 2'd1, 1'b0, 3'd2, 64'h0000_0000_0000_7FFF);
      send_lsu(5'd11, 64'h0000_0000_8001_0000, 2'd1, 1'b0, 3'd2, 64'hFFFF_FFFF_FFFF_8001);
      send_lsu(5'd12, 64'h1122_3344_5566_7788, 2'd3, 1'b1, 3'd3, 64'h0000_0011_2233_4455);
      send_exu(5'd13, 64'hCAFE_F00D_0000_0001);
      tick();
      check("load_retire", retire_cnt, exp_retire);

      // Scoreboard: set on issue, clear on the edge the load is written
      issue(5'd10);
      check("sb_set", 64'(busy), 64'h0000_0400);
      tick();
      send_lsu(5'd10, 64'h55, 2'd3, 1'b0, 3'd0, 64'h55);
      check("sb_wen_cycle", 64'(busy), 64'h0000_0400);
      tick();
      check("sb_clear", 64'(busy), 64'd0);

      // Set and clear to the same register on the same edge: set wins
      issue(5'd10);
      send_lsu(5'd10, 64'h66, 2'd3, 1'b0, 3'd0, 64'h66);
      issue(5'd10);
      check("sb_set_wins", 64'(busy), 64'h0000_0400);
      send_lsu(5'd10, 64'h77, 2'd3, 1'b0, 3'd0, 64'h77);
      tick();
      check("sb_clear2", 64'(busy), 64'd0);

      // Re-issue to a busy register; EXU writes do not clear the scoreboard
      issue(5'd12);
      issue(5'd12);
      check("sb_reissue", 64'(busy), 64'h0000_1000);
      send_exu(5'd12, 64'h1212);
      tick();
      check("sb_exu_no_clear", 64'(busy), 64'h0000_1000);
      send_lsu(5'd12, 64'h8000_0000_0000_0000, 2'd3, 1'b1, 3'd0, 64'h8000_0000_0000_0000);
      tick();
      check("sb_clear3", 64'(busy), 64'd0);

      // x0 handling
      send_exu(5'd0, 64'hDEAD);
      check("x0_wen", 64'(rf_wen), 64'd0);
      check("x0_retire", retire_cnt, exp_retire);
      issue(5'd0);
      check("x0_busy", 64'(busy), 64'd0);
      send_lsu(5'd0, 64'hFF, 2'd0, 1'b0, 3'd0, 64'hFFFF_FFFF_FFFF_FFFF);
      check("x0_lsu_wen", 64'(rf_wen), 64'd0);
      tick();
      check("x0_final_retire", retire_cnt, exp_retire);
      check("final_busy", 64'(busy), 64'd0);

      tick();
      tick();
      check("queue_drained", 64'(exp_q.size()), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
